// File: rtl/ssd_arbiter.sv
// Three-requester arbiter for a seven-segment display state code.
// It enforces a minimum hold time per grant and flags invalid codes.
module ssd_arbiter #(
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned MIN_HOLD_MS = 500,
    parameter logic [3:0]  IDLE_CODE   = 4'd0
) (
    input  logic       clkus,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [3:0] code0,
    input  logic [3:0] code1,
    input  logic [3:0] code2,
    output logic [2:0] gnt,
    output logic [3:0] state,
    output logic       busy,
    output logic       err
);

    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [15:0]   HOLD_MAX = 16'(MIN_HOLD_MS);
    localparam logic [3:0]    CODE_LIM = 4'd10;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_HOLD, S_OPEN, S_LINGER} fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [3:0]    state_q, state_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [1:0]    owner_q, owner_d;
    logic [3:0]    raw_q, raw_d;

    logic [PW-1:0] pre_inc_c;
    logic [15:0]   cnt_inc_c;
    logic          expired_c;
    logic          owner_req_c, higher_req_c;
    logic [3:0]    owner_code_c, sel_code_c;
    logic [1:0]    sel_idx_c;

    // Millisecond prescaler and hold counter advance; expiry is judged on the advanced count.
    always_comb begin
        pre_inc_c = pre_q + PW'(1);
        cnt_inc_c = cnt_q;
        if (pre_q == PRE_MAX) begin
            pre_inc_c = '0;
            cnt_inc_c = cnt_q + 16'd1;
        end
        expired_c = (cnt_inc_c == HOLD_MAX);
    end

    // Owner's request/code, requests above the owner, and the priority winner.
    always_comb begin
        owner_req_c  = req[0];
        higher_req_c = req[2] | req[1];
        owner_code_c = code0;
        case (owner_q)
            2'd1: begin
                owner_req_c  = req[1];
                higher_req_c = req[2];
                owner_code_c = code1;
            end
            2'd2: begin
                owner_req_c  = req[2];
                higher_req_c = 1'b0;
                owner_code_c = code2;
            end
            default: ;
        endcase
        sel_idx_c  = 2'd0;
        sel_code_c = code0;
        if (req[2]) begin
            sel_idx_c  = 2'd2;
            sel_code_c = code2;
        end else if (req[1]) begin
            sel_idx_c  = 2'd1;
            sel_code_c = code1;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        gnt_d   = gnt_q;
        state_d = state_q;
        err_d   = 1'b0;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        raw_d   = raw_q;
        case (fsm_q)
            S_IDLE: begin
                gnt_d   = '0;
                state_d = IDLE_CODE;
                if (|req) fsm_d = S_ARB;
            end
            S_ARB: begin
                gnt_d = '0;
                if (|req) begin
                    owner_d = sel_idx_c;
                    gnt_d   = 3'b001 << sel_idx_c;
                    raw_d   = sel_code_c;
                    state_d = (sel_code_c < CODE_LIM) ? sel_code_c : IDLE_CODE;
                    err_d   = (sel_code_c >= CODE_LIM);
                    pre_d   = '0;
                    cnt_d   = '0;
                    fsm_d   = (MIN_HOLD_MS == 0) ? S_OPEN : S_HOLD;
                end else begin
                    state_d = IDLE_CODE;
                    fsm_d   = S_IDLE;
                end
            end
            S_HOLD: begin
                pre_d = pre_inc_c;
                cnt_d = cnt_inc_c;
                if (!owner_req_c) begin
                    gnt_d = '0;
                    fsm_d = expired_c ? S_ARB : S_LINGER;
                end else begin
                    raw_d   = owner_code_c;
                    state_d = (owner_code_c < CODE_LIM) ? owner_code_c : IDLE_CODE;
                    err_d   = (owner_code_c >= CODE_LIM) && (owner_code_c != raw_q);
                    if (expired_c) fsm_d = S_OPEN;
                end
            end
            S_LINGER: begin
                pre_d = pre_inc_c;
                cnt_d = cnt_inc_c;
                if (expired_c) fsm_d = S_ARB;
            end
            S_OPEN: begin
                if (!owner_req_c || higher_req_c) begin
                    gnt_d = '0;
                    fsm_d = S_ARB;
                end else begin
                    raw_d   = owner_code_c;
                    state_d = (owner_code_c < CODE_LIM) ? owner_code_c : IDLE_CODE;
                    err_d   = (owner_code_c >= CODE_LIM) && (owner_code_c != raw_q);
                end
            end
            default: fsm_d = S_IDLE;
        endcase
        busy_d = (fsm_d != S_IDLE);
    end

    always_ff @(posedge clkus) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            gnt_q   <= '0;
            state_q <= IDLE_CODE;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            pre_q   <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
            raw_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            gnt_q   <= gnt_d;
            state_q <= state_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            raw_q   <= raw_d;
        end
    end

    assign gnt   = gnt_q;
    assign state = state_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ssd_arbiter.sv
// Scoreboard bench for ssd_arbiter: timed expectations are queued by the stimulus
// and popped by a monitor on the falling edge of the cycle they refer to.
module tb_ssd_arbiter;

    localparam logic [3:0] IC = 4'hF;

    typedef struct {
        int         cyc;
        logic [2:0] g;
        logic [3:0] s;
        logic       b;
        logic       e;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [3:0] code0, code1, code2;
    logic [2:0] gnt;
    logic [3:0] state;
    logic       busy, err;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    bit   reported = 1'b0;
    exp_t exq[$];

    ssd_arbiter #(.TICK_DIV(10), .MIN_HOLD_MS(3), .IDLE_CODE(IC)) dut (
        .clkus(clk), .rst_n(rst_n), .req(req),
        .code0(code0), .code1(code1), .code2(code2),
        .gnt(gnt), .state(state), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle; flush leftovers once stimulus is done.
    always @(negedge clk) begin
        exp_t x;
        while (exq.size() > 0 && exq[0].cyc <= cyc) begin
            x = exq.pop_front();
            checks++;
            if (x.cyc != cyc || gnt !== x.g || state !== x.s || busy !== x.b || err !== x.e) begin
                errors++;
                $display("FAIL %s cyc=%0d/%0d gnt=%b exp %b state=%0d exp %0d busy=%b exp %b err=%b exp %b",
                         x.nm, cyc, x.cyc, gnt, x.g, state, x.s, busy, x.b, err, x.e);
            end
        end
        if (done && !reported) begin
            while (exq.size() > 0) begin
                x = exq.pop_front();
                checks++;
                errors++;
                $display("FAIL %s never checked (cyc %0d)", x.nm, x.cyc);
            end
            reported = 1'b1;
        end
    end

    function automatic void push(input int c, input logic [2:0] g, input logic [3:0] s,
                                 input logic b, input logic e, input string n);
        exp_t x;
        x.cyc = c; x.g = g; x.s = s; x.b = b; x.e = e; x.nm = n;
        exq.push_back(x);
    endfunction

    // Advance so that inputs driven on return are sampled at edge e.
    task automatic at(input int e);
        while (cyc < e - 1) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int ea, eb, ed, ef, eg;
        rst_n = 1'b0;
        req   = 3'b000;
        code0 = 4'd0; code1 = 4'd0; code2 = 4'd0;
        push(2, 3'b000, IC, 1'b0, 1'b0, "reset_state");
        push(4, 3'b000, IC, 1'b0, 1'b0, "idle_after_reset");
        at(3);
        rst_n = 1'b1;

        // Simple grant, code following, no preemption in HOLD, preemption in OPEN.
        ea = 7;
        push(ea-1,  3'b000, IC,   1'b1, 1'b0, "a_arb_cycle");
        push(ea,    3'b001, 4'd4, 1'b1, 1'b0, "a_grant");
        push(ea+10, 3'b001, 4'd6, 1'b1, 1'b0, "a_follow_code");
        push(ea+29, 3'b001, 4'd6, 1'b1, 1'b0, "a_no_preempt_hold");
        push(ea+30, 3'b001, 4'd6, 1'b1, 1'b0, "a_open_still_owner");
        push(ea+32, 3'b100, 4'd7, 1'b1, 1'b0, "a_preempt_grant");
        push(ea+34, 3'b000, 4'd7, 1'b1, 1'b0, "a_drop_gnt_clear");
        push(ea+62, 3'b000, 4'd7, 1'b1, 1'b0, "a_linger_expire_arb");
        push(ea+63, 3'b000, IC,   1'b0, 1'b0, "a_back_idle");
        at(ea-1);  req = 3'b001; code0 = 4'd4;
        at(ea+5);  req = 3'b101; code2 = 4'd7;
        at(ea+10); code0 = 4'd6;
        at(ea+34); req = 3'b000;

        // Release during HOLD; LINGER ignores all requests.
        eb = ea + 65;
        push(eb,    3'b010, 4'd2, 1'b1, 1'b0, "b_grant");
        push(eb+9,  3'b010, 4'd2, 1'b1, 1'b0, "b_before_drop");
        push(eb+10, 3'b000, 4'd2, 1'b1, 1'b0, "b_drop_gnt_clear");
        push(eb+20, 3'b000, 4'd2, 1'b1, 1'b0, "b_linger_ignores_req");
        push(eb+29, 3'b000, 4'd2, 1'b1, 1'b0, "b_linger_holds_code");
        push(eb+30, 3'b000, 4'd2, 1'b1, 1'b0, "b_arb_after_expiry");
        push(eb+31, 3'b000, IC,   1'b0, 1'b0, "b_idle");
        at(eb-1);  req = 3'b010; code1 = 4'd2;
        at(eb+10); req = 3'b000;
        at(eb+15); req = 3'b100; code2 = 4'd7;
        at(eb+20); req = 3'b000;

        // Invalid code in OPEN, lower priority ignored, then simultaneous drop and higher request.
        ed = eb + 33;
        push(ed,    3'b010, 4'd3, 1'b1, 1'b0, "d_grant");
        push(ed+30, 3'b010, 4'd3, 1'b1, 1'b0, "d_open");
        push(ed+33, 3'b010, IC,   1'b1, 1'b1, "d_bad_code_err");
        push(ed+34, 3'b010, IC,   1'b1, 1'b0, "d_err_one_cycle");
        push(ed+36, 3'b010, 4'd5, 1'b1, 1'b0, "d_good_code");
        push(ed+38, 3'b010, 4'd5, 1'b1, 1'b0, "d_lower_prio_ignored");
        push(ed+40, 3'b000, 4'd5, 1'b1, 1'b0, "c_arb");
        push(ed+41, 3'b100, 4'd9, 1'b1, 1'b0, "c_grant_highest");
        push(ed+42, 3'b100, 4'd9, 1'b1, 1'b0, "c_single_arb");
        at(ed-1);  req = 3'b010; code1 = 4'd3;
        at(ed+33); code1 = 4'd12;
        at(ed+36); code1 = 4'd5;
        at(ed+37); req = 3'b011;
        at(ed+39); req = 3'b010;
        at(ed+40); req = 3'b101; code2 = 4'd9;

        // Reset mid-HOLD with req2 held, regrant and a fresh hold count.
        ef = ed + 41;
        eg = ef + 17;
        push(ef+15, 3'b000, IC,   1'b0, 1'b0, "f_reset_mid_hold");
        push(ef+16, 3'b000, IC,   1'b1, 1'b0, "f_arb_after_reset");
        push(eg,    3'b100, 4'd9, 1'b1, 1'b0, "f_regrant");
        push(eg+25, 3'b000, 4'd9, 1'b1, 1'b0, "f_drop_to_linger");
        push(eg+29, 3'b000, 4'd9, 1'b1, 1'b0, "f_fresh_hold_running");
        push(eg+30, 3'b000, 4'd9, 1'b1, 1'b0, "f_fresh_hold_expiry");
        push(eg+31, 3'b000, IC,   1'b0, 1'b0, "f_idle");
        at(ef+15); rst_n = 1'b0;
        at(ef+16); rst_n = 1'b1;
        at(eg+25); req = 3'b000;
        at(eg+34);

        done = 1'b1;
        for (int i = 0; i < 10 && !reported; i++) @(posedge clk);
        if (!reported) $display("FAIL monitor_flush did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
